// File: rtl/cpu_pkg.sv
// Shared decode constants, ALU/result-select enums and the load-lane helper
// for the single-cycle RV32I core.
package cpu_pkg;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU,
    RES_LOAD,
    RES_PC4,
    RES_UIMM
  } res_sel_e;

  // Pick the addressed byte/half out of a little-endian word and extend it.
  // A misaligned half uses the half named by addr[1]; lw always takes the
  // whole word regardless of the low address bits.
  function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                               input logic [1:0]  addr_lo,
                                               input logic [31:0] rdata);
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    logic [31:0] v_res;
    case (addr_lo)
      2'd0:    v_byte = rdata[7:0];
      2'd1:    v_byte = rdata[15:8];
      2'd2:    v_byte = rdata[23:16];
      default: v_byte = rdata[31:24];
    endcase
    v_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   v_res = {{24{v_byte[7]}}, v_byte};
      F3_LBU:  v_res = {24'd0, v_byte};
      F3_LH:   v_res = {{16{v_half[15]}}, v_half};
      F3_LHU:  v_res = {16'd0, v_half};
      default: v_res = rdata;
    endcase
    return v_res;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port,
// x0 hard-wired to zero, whole array cleared synchronously on reset.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [31:0] r_regs [32];

  // Register write port with synchronous clear taking priority over writes.
  // NOTE: this array is reset on purpose (architectural state must clear);
  // ordinary data memories are left unreset so they map onto RAM macros.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_regs[i_raddr2];

endmodule

// File: rtl/cpu.sv
// Single-cycle RV32I core: registered PC, combinational decode, ALU, branch
// resolution, load extraction and write-back mux around cpu_regfile.
module cpu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  output logic [31:0] PC,
  input  logic [31:0] Instr,
  output logic [31:0] ALUResult,
  output logic        MemWrite,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  output logic [31:0] Final_Result
);

  logic [31:0] r_pc;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic        w_funct7_5;

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_src_a_pc;
  logic        w_src_b_imm;
  logic        w_branch;
  logic        w_jal;
  logic        w_jalr;
  logic [31:0] w_imm;
  alu_op_e     w_alu_op;
  res_sel_e    w_res_sel;

  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_result;
  logic        w_take_branch;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_target;
  logic [31:0] w_pc_next;
  logic [31:0] w_load_data;
  logic [31:0] w_result;

  assign w_opcode   = Instr[6:0];
  assign w_rd       = Instr[11:7];
  assign w_funct3   = Instr[14:12];
  assign w_rs1      = Instr[19:15];
  assign w_rs2      = Instr[24:20];
  assign w_funct7_5 = Instr[30];

  assign w_imm_i = {{20{Instr[31]}}, Instr[31:20]};
  assign w_imm_s = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
  assign w_imm_b = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
  assign w_imm_u = {Instr[31:12], 12'd0};
  assign w_imm_j = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};

  // Main decoder: control signals and immediate selection from the opcode.
  // NOTE: every output gets a default before the case so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;
    w_src_a_pc  = 1'b0;
    w_src_b_imm = 1'b1;
    w_branch    = 1'b0;
    w_jal       = 1'b0;
    w_jalr      = 1'b0;
    w_imm       = w_imm_i;
    w_alu_op    = ALU_ADD;
    w_res_sel   = RES_ALU;
    case (w_opcode)
      OP_LOAD: begin
        w_reg_write = 1'b1;
        w_res_sel   = RES_LOAD;
      end
      OP_IMM: begin
        w_reg_write = 1'b1;
        case (w_funct3)
          3'b000:  w_alu_op = ALU_ADD;
          3'b001:  w_alu_op = ALU_SLL;
          3'b010:  w_alu_op = ALU_SLT;
          3'b011:  w_alu_op = ALU_SLTU;
          3'b100:  w_alu_op = ALU_XOR;
          3'b101:  w_alu_op = w_funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
      end
      OP_REG: begin
        w_reg_write = 1'b1;
        w_src_b_imm = 1'b0;
        case (w_funct3)
          3'b000:  w_alu_op = w_funct7_5 ? ALU_SUB : ALU_ADD;
          3'b001:  w_alu_op = ALU_SLL;
          3'b010:  w_alu_op = ALU_SLT;
          3'b011:  w_alu_op = ALU_SLTU;
          3'b100:  w_alu_op = ALU_XOR;
          3'b101:  w_alu_op = w_funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
      end
      OP_STORE: begin
        // sb/sh are treated as sw: funct3 is ignored.
        w_mem_write = 1'b1;
        w_imm       = w_imm_s;
      end
      OP_BRANCH: begin
        w_branch    = 1'b1;
        w_src_b_imm = 1'b0;
        w_alu_op    = ALU_SUB;
        w_imm       = w_imm_b;
      end
      OP_JAL: begin
        w_reg_write = 1'b1;
        w_jal       = 1'b1;
        w_src_a_pc  = 1'b1;
        w_imm       = w_imm_j;
        w_res_sel   = RES_PC4;
      end
      OP_JALR: begin
        w_reg_write = 1'b1;
        w_jalr      = 1'b1;
        w_res_sel   = RES_PC4;
      end
      OP_LUI: begin
        w_reg_write = 1'b1;
        w_imm       = w_imm_u;
        w_res_sel   = RES_UIMM;
      end
      OP_AUIPC: begin
        w_reg_write = 1'b1;
        w_src_a_pc  = 1'b1;
        w_imm       = w_imm_u;
      end
      default: begin
        // Unknown opcode: defaults give no write, no store, PC+4.
      end
    endcase
  end

  cpu_regfile u_regfile (
    .clk      (clk),
    .i_reset  (Reset),
    .i_we     (w_reg_write),
    .i_waddr  (w_rd),
    .i_wdata  (w_result),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

  assign w_alu_a = w_src_a_pc  ? r_pc  : w_rs1_data;
  assign w_alu_b = w_src_b_imm ? w_imm : w_rs2_data;
  assign w_shamt = w_alu_b[4:0];

  // ALU: 32-bit wrap-around arithmetic, shifts use the low five bits of B.
  always_comb begin
    w_alu_result = 32'd0;
    case (w_alu_op)
      ALU_ADD:  w_alu_result = w_alu_a + w_alu_b;
      ALU_SUB:  w_alu_result = w_alu_a - w_alu_b;
      ALU_SLL:  w_alu_result = w_alu_a << w_shamt;
      ALU_SLT:  w_alu_result = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
      ALU_SLTU: w_alu_result = {31'd0, w_alu_a < w_alu_b};
      ALU_XOR:  w_alu_result = w_alu_a ^ w_alu_b;
      ALU_SRL:  w_alu_result = w_alu_a >> w_shamt;
      ALU_SRA:  w_alu_result = $unsigned($signed(w_alu_a) >>> w_shamt);
      ALU_OR:   w_alu_result = w_alu_a | w_alu_b;
      ALU_AND:  w_alu_result = w_alu_a & w_alu_b;
      default:  w_alu_result = 32'd0;
    endcase
  end

  // Branch condition from the two register operands.
  always_comb begin
    w_take_branch = 1'b0;
    if (w_branch) begin
      case (w_funct3)
        F3_BEQ:  w_take_branch = (w_rs1_data == w_rs2_data);
        F3_BNE:  w_take_branch = (w_rs1_data != w_rs2_data);
        F3_BLT:  w_take_branch = ($signed(w_rs1_data) <  $signed(w_rs2_data));
        F3_BGE:  w_take_branch = ($signed(w_rs1_data) >= $signed(w_rs2_data));
        F3_BLTU: w_take_branch = (w_rs1_data <  w_rs2_data);
        F3_BGEU: w_take_branch = (w_rs1_data >= w_rs2_data);
        default: w_take_branch = 1'b0;
      endcase
    end
  end

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_pc_target = r_pc + w_imm;

  // Next-PC selection: jalr target, PC-relative target, or fall-through.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_jalr) begin
      w_pc_next = {w_alu_result[31:1], 1'b0};
    end else if (w_jal || w_take_branch) begin
      w_pc_next = w_pc_target;
    end
  end

  assign w_load_data = load_extract(w_funct3, w_alu_result[1:0], ReadData);

  // Write-back mux; also drives Final_Result when nothing is written.
  always_comb begin
    w_result = w_alu_result;
    case (w_res_sel)
      RES_ALU:  w_result = w_alu_result;
      RES_LOAD: w_result = w_load_data;
      RES_PC4:  w_result = w_pc_plus4;
      RES_UIMM: w_result = w_imm;
      default:  w_result = w_alu_result;
    endcase
  end

  // Program counter register; reset wins over any pending update.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_pc <= 32'd0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign PC           = r_pc;
  assign ALUResult    = w_alu_result;
  assign MemWrite     = w_mem_write;
  assign WriteData    = w_rs2_data;
  assign Final_Result = w_result;

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for the single-cycle core: the stimulus process drives one
// instruction per cycle and queues hand-computed expectations; a monitor
// process pops and compares them on the falling edge of the same cycle.
module tb_cpu;

  logic        clk;
  logic        Reset;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic [31:0] ALUResult;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] Final_Result;

  typedef enum logic [2:0] { S_PC, S_ALU, S_MW, S_WD, S_FR } sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t q_exp[$];
  int   checks;
  int   errors;
  bit   done;

  localparam logic [31:0] NOP = 32'h00000013;

  cpu dut (
    .clk          (clk),
    .Reset        (Reset),
    .PC           (PC),
    .Instr        (Instr),
    .ALUResult    (ALUResult),
    .MemWrite     (MemWrite),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .Final_Result (Final_Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expect_sig(input string name, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    q_exp.push_back(e);
  endtask

  // Advance one clock and present the next instruction shortly after the edge.
  task automatic step(input logic [31:0] instr, input logic [31:0] rdata, input logic rst);
    @(posedge clk);
    #1;
    Instr    = instr;
    ReadData = rdata;
    Reset    = rst;
  endtask

  // Monitor: everything queued this cycle is compared mid-cycle.
  always @(negedge clk) begin
    while (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      case (e.sig)
        S_PC:    check(e.name, PC, e.val);
        S_ALU:   check(e.name, ALUResult, e.val);
        S_MW:    check(e.name, {31'd0, MemWrite}, e.val);
        S_WD:    check(e.name, WriteData, e.val);
        default: check(e.name, Final_Result, e.val);
      endcase
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    done     = 1'b0;
    Reset    = 1'b1;
    Instr    = NOP;
    ReadData = 32'd0;

    // Cycle 0: one reset edge, then release
    step(NOP, 32'd0, 1'b0);
    expect_sig("reset_pc", S_PC, 32'h0);
    expect_sig("reset_nop_fr", S_FR, 32'h0);
    expect_sig("reset_mw", S_MW, 32'd0);

    // Cycles 1..3: nops advance PC by 4
    step(NOP, 32'd0, 1'b0);
    expect_sig("nop_pc4", S_PC, 32'h4);
    step(NOP, 32'd0, 1'b0);
    expect_sig("nop_pc8", S_PC, 32'h8);
    step(NOP, 32'd0, 1'b0);
    expect_sig("nop_pcc", S_PC, 32'hC);

    // Cycle 4: beq x0,x0,+8 at 0x10
    step(32'h00000463, 32'd0, 1'b0);
    expect_sig("beq_pc", S_PC, 32'h10);
    expect_sig("beq_mw", S_MW, 32'd0);
    expect_sig("beq_fr_is_alu", S_FR, 32'h0);

    // Cycle 5: branch taken -> 0x18; lb x1,0x60(x0)
    step(32'h06000083, 32'h01B1061A, 1'b0);
    expect_sig("beq_taken_pc", S_PC, 32'h18);
    expect_sig("lb_addr", S_ALU, 32'h60);
    expect_sig("lb_mw", S_MW, 32'd0);
    expect_sig("lb_fr", S_FR, 32'h0000001A);

    // Cycle 6: lb x10,0x60(x0)
    step(32'h06000503, 32'hA1230207, 1'b0);
    expect_sig("lb_x10_fr", S_FR, 32'h7);

    // Cycle 7: addi x10,x10,7
    step(32'h00750513, 32'd0, 1'b0);
    expect_sig("addi_fr", S_FR, 32'd14);

    // Cycle 8: sw x10,0x54(x0)
    step(32'h04A02A23, 32'd0, 1'b0);
    expect_sig("sw_pc", S_PC, 32'h24);
    expect_sig("sw_mw", S_MW, 32'd1);
    expect_sig("sw_addr", S_ALU, 32'h54);
    expect_sig("sw_wd", S_WD, 32'd14);
    expect_sig("sw_fr_is_alu", S_FR, 32'h54);

    // Cycles 9..11: byte-load sign handling
    step(32'h06000083, 32'h000000F0, 1'b0);
    expect_sig("lb_neg_fr", S_FR, 32'hFFFFFFF0);
    step(32'h06004083, 32'h000000F0, 1'b0);
    expect_sig("lbu_fr", S_FR, 32'h000000F0);
    step(32'h06100083, 32'h00008000, 1'b0);
    expect_sig("lb61_addr", S_ALU, 32'h61);
    expect_sig("lb61_fr", S_FR, 32'hFFFFFF80);

    // Cycle 12: addi x0,x0,5 (result visible but not written)
    step(32'h00500013, 32'd0, 1'b0);
    expect_sig("addi_x0_fr", S_FR, 32'd5);

    // Cycle 13: addi x2,x0,0 -> x0 still reads 0
    step(32'h00000113, 32'd0, 1'b0);
    expect_sig("x0_reads0", S_FR, 32'd0);

    // Cycle 14: add x3,x10,x1 = 14 + 0xFFFFFF80
    step(32'h001501B3, 32'd0, 1'b0);
    expect_sig("add_fr", S_FR, 32'hFFFFFF8E);

    // Cycle 15: sub x4,x10,x1 = 14 - (-128)
    step(32'h40150233, 32'd0, 1'b0);
    expect_sig("sub_fr", S_FR, 32'h0000008E);

    // Cycle 16: srai x8,x1,4
    step(32'h4040D413, 32'd0, 1'b0);
    expect_sig("srai_fr", S_FR, 32'hFFFFFFF8);

    // Cycle 17: lui x5,0x12345
    step(32'h123452B7, 32'd0, 1'b0);
    expect_sig("lui_fr", S_FR, 32'h12345000);

    // Cycle 18: jal x6,+8 at 0x4C
    step(32'h0080036F, 32'd0, 1'b0);
    expect_sig("jal_pc", S_PC, 32'h4C);
    expect_sig("jal_link", S_FR, 32'h50);

    // Cycle 19: at 0x54, bne x0,x0,+8 not taken
    step(32'h00001463, 32'd0, 1'b0);
    expect_sig("jal_target_pc", S_PC, 32'h54);

    // Cycle 20: fall-through; addi x10,x0,99 while reset asserted
    step(32'h06300513, 32'd0, 1'b1);
    expect_sig("bne_not_taken_pc", S_PC, 32'h58);
    expect_sig("reset_cycle_fr", S_FR, 32'd99);

    // Cycle 21: reset had priority: PC=0, x10 cleared
    step(32'h00050393, 32'd0, 1'b0);
    expect_sig("midreset_pc", S_PC, 32'h0);
    expect_sig("midreset_x10", S_FR, 32'd0);

    // Cycle 22: execution resumes
    step(NOP, 32'd0, 1'b0);
    expect_sig("post_reset_pc", S_PC, 32'h4);

    @(negedge clk);
    #1;
    check("queue_drained", q_exp.size(), 0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
